axrm_seq_ctrl: RTL

- Sequenced 8x8 approximate recursive multiplier built around one shared 2x2 multiplier cell.
- A 4-bit step counter schedules the 16 digit-pair partial products (2-bit a-digit i, 2-bit b-digit j) into a 16-bit accumulator over 16 cycles.
- It is the area-lean, time-multiplexed counterpart of the parallel 16-cell AxRM arrays. Valid/ready handshakes on both the operand side and the result side.

---
 rtl/axrm_seq_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axrm_seq_ctrl.sv
// axrm_seq_ctrl -- sequenced 8x8 approximate recursive multiplier.
//
// One shared 2x2 multiplier cell is reused over 16 cycles. A 4-bit step
// counter walks the digit pairs (i = step[1:0], j = step[3:2]). Each cycle
// it adds cell(a_i, b_j) << (2i+2j) into a 16-bit accumulator. When approx
// mode is latched, the low a-digits (i < APPROX_DIGITS) use an approximate
// cell that maps 3x3 to 7 instead of 9.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand request
//   in_ready   out  high in IDLE, block accepts operands
//   a, b       in   8-bit unsigned operands, latched on accept
//   approx     in   approximate mode for this operation, latched on accept
//   out_valid  out  result available, held until out_ready
//   out_ready  in   consumer accepts the result
//   result     out  16-bit product
//   busy       out  high in CALC or DONE
//
// Optional feature macro: AXRM_EARLY_TERM_EN. When defined, a zero operand
// skips the schedule and goes straight to DONE with result 0.

module axrm_seq_ctrl #(
    parameter int unsigned APPROX_DIGITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        approx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic        approx_q, approx_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] result_q, result_d;
    logic        out_valid_q, out_valid_d;

    logic [1:0]  dig_i, dig_j;
    logic [1:0]  a_dig, b_dig;
    logic        use_approx;
    logic [3:0]  cell_p;
    logic [3:0]  shamt;
    logic [15:0] pp;
    logic [15:0] acc_sum;

    // Shared 2x2 cell and shifted partial product for the current step.
    always_comb begin
        dig_i      = step_q[1:0];
        dig_j      = step_q[3:2];
        a_dig      = a_q[{dig_i, 1'b0} +: 2];
        b_dig      = b_q[{dig_j, 1'b0} +: 2];
        use_approx = approx_q && (32'(dig_i) < APPROX_DIGITS);
        cell_p     = {2'b00, a_dig} * {2'b00, b_dig};
        if (use_approx && (a_dig == 2'd3) && (b_dig == 2'd3)) begin
            cell_p = 4'd7;
        end
        shamt   = {1'b0, dig_i, 1'b0} + {1'b0, dig_j, 1'b0};
        pp      = {12'd0, cell_p} << shamt;
        acc_sum = acc_q + pp;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        approx_d    = approx_q;
        acc_d       = acc_q;
        step_d      = step_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    approx_d = approx;
                    acc_d    = '0;
                    step_d   = '0;
                    state_d  = S_CALC;
`ifdef AXRM_EARLY_TERM_EN
                    if ((a == 8'd0) || (b == 8'd0)) begin
                        result_d    = '0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                acc_d  = acc_sum;
                // The 4-bit counter wraps 15->0 exactly on the final step.
                step_d = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    result_d    = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            approx_q    <= 1'b0;
            acc_q       <= '0;
            step_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            approx_q    <= approx_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
